// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: 8N1 UART receiver feeding a first-word-fall-through FIFO.
// Received bytes are queued for the command interpreter. Bad stop bits pulse
// frame_error, and bytes dropped because the FIFO is full set a sticky overrun.
// Optional build macro UART_RX_PARITY_EN switches the frame to 8E1. With it,
// parity errors are folded into frame_error.
module uart_rx_fifo #(
  parameter int CLK_FREQ   = 25000000,
  parameter int BIT_RATE   = 115200,
  parameter int FIFO_DEPTH = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  input  logic       read,
  output logic [7:0] rx_data,
  output logic       rx_empty,
  output logic       rx_full,
  output logic       frame_error,
  output logic       overrun
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BIT_RATE;
  localparam int HALF         = CLKS_PER_BIT / 2;
  localparam int CW           = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int AW           = $clog2(FIFO_DEPTH);

  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(HALF - 1);
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(FIFO_DEPTH);

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

  // Receiver state.
  logic          sync1_q, sync2_q;
  logic          rxs;
  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    shift_q, shift_d;
  logic          push_q, push_d;
  logic          ferr_q, ferr_d;
`ifdef UART_RX_PARITY_EN
  logic          perr_q, perr_d;
`endif

  // FIFO state.
  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q, count_d;
  logic          overrun_q;
  logic          do_push, do_pop;

  assign rxs = sync2_q;

  // Two-flop synchroniser for the asynchronous serial line, idling high.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= rx;
      sync2_q <= sync1_q;
    end
  end

  // Receiver registers; reset aborts any frame in progress.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      push_q  <= 1'b0;
      ferr_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      perr_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      push_q  <= push_d;
      ferr_q  <= ferr_d;
`ifdef UART_RX_PARITY_EN
      perr_q  <= perr_d;
`endif
    end
  end

  // Receiver next state: start detect, mid-bit sampling, and stop check.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CW'(1);
    idx_d   = idx_q;
    shift_d = shift_q;
    push_d  = 1'b0;
    ferr_d  = 1'b0;
`ifdef UART_RX_PARITY_EN
    perr_d  = perr_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (!rxs) state_d = S_START;
      end
      S_START: begin
        if (cnt_q == CNT_HALF) begin
          cnt_d   = '0;
          idx_d   = '0;
          state_d = rxs ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          shift_d = {rxs, shift_q[7:1]};
          idx_d   = idx_q + 3'd1;
          if (idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          perr_d  = ^{shift_q, rxs};
          state_d = S_STOP;
        end
      end
`endif
      S_STOP: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = S_IDLE;
`ifdef UART_RX_PARITY_EN
          if (rxs && !perr_q) push_d = 1'b1;
          else                ferr_d = 1'b1;
`else
          if (rxs) push_d = 1'b1;
          else     ferr_d = 1'b1;
`endif
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // A pop needs a head entry. A push into a full FIFO is only accepted
  // when a pop frees a slot in the same cycle.
  always_comb begin
    do_pop  = read && (count_q != '0);
    do_push = push_q && ((count_q != CNT_FULL) || do_pop);
    count_d = count_q;
    if (do_push && !do_pop)      count_d = count_q + 1'b1;
    else if (!do_push && do_pop) count_d = count_q - 1'b1;
  end

  // FIFO storage, pointers, occupancy and the sticky overrun flag.
  // shift_q is stable until the next DATA state, so it is written directly
  // in the cycle after the stop sample.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      overrun_q <= 1'b0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= shift_q;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (do_pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
      if (push_q && !do_push) overrun_q <= 1'b1;
    end
  end

  assign rx_data     = mem_q[rd_ptr_q];
  assign rx_empty    = (count_q == '0);
  assign rx_full     = (count_q == CNT_FULL);
  assign frame_error = ferr_q;
  assign overrun     = overrun_q;

endmodule
